// File: rtl/dp_ram_ring_reader.sv
// Ring-buffer read engine: fetches entries from a registered-address RAM port into a
// 2-entry output FIFO and streams them out. Optional level output: DP_RAM_RING_READER_LEVEL_EN.
module dp_ram_ring_reader #(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH:0]   wr_ptr,
   input  logic                     flush,
   output logic [ADDRESS_WIDTH-1:0] ram_rd_address,
   input  logic [DATA_WIDTH-1:0]    ram_rd_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic [ADDRESS_WIDTH:0]   rd_ptr,
   output logic                     empty
`ifdef DP_RAM_RING_READER_LEVEL_EN
   ,
   output logic [ADDRESS_WIDTH:0]   level
`endif
);

   logic [ADDRESS_WIDTH:0] fetch_ptr;
   logic                   in_flight;
   logic [DATA_WIDTH-1:0]  fifo_mem [2];
   logic                   wr_idx;
   logic                   rd_idx;
   logic [1:0]             count;
   logic [1:0]             occupied;
   logic                   pop;
   logic                   issue;

   assign pop            = m_valid && m_ready;
   assign occupied       = count + {1'b0, in_flight};
   // A pop this cycle frees a slot for the fetch issued in the same cycle.
   assign issue          = (fetch_ptr != wr_ptr) && ((occupied - {1'b0, pop}) < 2'd2) && !flush;
   assign ram_rd_address = fetch_ptr[ADDRESS_WIDTH-1:0];
   assign m_valid        = (count != 2'd0);
   assign m_data         = fifo_mem[rd_idx];
   assign empty          = (rd_ptr == wr_ptr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_ptr <= '0;
         rd_ptr    <= '0;
         in_flight <= 1'b0;
      end else if (flush) begin
         fetch_ptr <= wr_ptr;
         rd_ptr    <= wr_ptr;
         in_flight <= 1'b0;
      end else begin
         if (issue)
            fetch_ptr <= fetch_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         in_flight <= issue;
      end
   end

   // RAM data arriving for last cycle's fetch is pushed; the issue rule guarantees room.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_idx      <= 1'b0;
         rd_idx      <= 1'b0;
         count       <= 2'd0;
      end else if (flush) begin
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (in_flight) begin
            fifo_mem[wr_idx] <= ram_rd_data;
            wr_idx           <= ~wr_idx;
         end
         if (pop)
            rd_idx <= ~rd_idx;
         count <= count + {1'b0, in_flight} - {1'b0, pop};
      end
   end

`ifdef DP_RAM_RING_READER_LEVEL_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         level <= '0;
      else
         level <= wr_ptr - rd_ptr;
   end
`endif

endmodule

// File: tb/tb_dp_ram_ring_reader.sv
// Directed self-checking bench for dp_ram_ring_reader with a behavioural registered-address RAM.
// Uses a 16-entry ring so wrap and MSB toggling are reachable with short sequences.
module tb_dp_ram_ring_reader;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   wr_ptr;
   logic          flush;
   logic [AW-1:0] ram_rd_address;
   logic [DW-1:0] ram_rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [AW:0]   rd_ptr;
   logic          empty;
`ifdef DP_RAM_RING_READER_LEVEL_EN
   logic [AW:0]   level;
`endif

   logic [DW-1:0] ram [16];
   int checks   = 0;
   int failures = 0;

   dp_ram_ring_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_ptr(wr_ptr),
      .flush(flush),
      .ram_rd_address(ram_rd_address),
      .ram_rd_data(ram_rd_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .rd_ptr(rd_ptr),
      .empty(empty)
`ifdef DP_RAM_RING_READER_LEVEL_EN
      ,
      .level(level)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      ram_rd_data <= ram[ram_rd_address];

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      wr_ptr  = '0;
      flush   = 1'b0;
      m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_a0();
      for (int i = 0; i < 4; i++)
         ram[i] = 8'hA0 + 8'(i);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd0) begin failures++; $display("[TB] FAIL reset_rd_ptr got=%0d exp=0", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
      if (ram_rd_address !== 4'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d exp=0", ram_rd_address); end
      if (m_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", m_data); end
   endtask

   task automatic test_stream();
      do_reset();
      load_a0();
      m_ready = 1'b1;
      wr_ptr  = 5'd4;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_n1_valid got=%b exp=0", m_valid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 2;
         if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid beat=%0d got=%b exp=1", i, m_valid); end
         if (m_data !== 8'hA0 + 8'(i)) begin failures++; $display("[TB] FAIL stream_data beat=%0d got=%h exp=%h", i, m_data, 8'hA0 + 8'(i)); end
      end
      @(negedge clk);
      checks += 3;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_end_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd4) begin failures++; $display("[TB] FAIL stream_rd_ptr got=%0d exp=4", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL stream_empty got=%b exp=1", empty); end
   endtask

   task automatic test_backpressure();
      do_reset();
      load_a0();
      m_ready = 1'b0;
      wr_ptr  = 5'd4;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks += 3;
         if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, m_valid); end
         if (m_data !== 8'hA0) begin failures++; $display("[TB] FAIL bp_hold_data cyc=%0d got=%h exp=a0", c, m_data); end
         if (ram_rd_address !== 4'd2) begin failures++; $display("[TB] FAIL bp_stall_addr cyc=%0d got=%0d exp=2", c, ram_rd_address); end
      end
      m_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checks += 2;
         if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid beat=%0d got=%b exp=1", i, m_valid); end
         if (m_data !== 8'hA0 + 8'(i)) begin failures++; $display("[TB] FAIL bp_data beat=%0d got=%h exp=%h", i, m_data, 8'hA0 + 8'(i)); end
      end
      @(negedge clk);
      checks += 2;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_end_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd4) begin failures++; $display("[TB] FAIL bp_rd_ptr got=%0d exp=4", rd_ptr); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] exp_wrap [4];
      exp_wrap = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      ram[14] = 8'h11;
      ram[15] = 8'h22;
      ram[0]  = 8'h33;
      ram[1]  = 8'h44;
      m_ready = 1'b1;
      wr_ptr  = 5'd14;
      flush   = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks += 2;
      if (rd_ptr !== 5'd14) begin failures++; $display("[TB] FAIL wrap_start_rd_ptr got=%0d exp=14", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_start_empty got=%b exp=1", empty); end
      wr_ptr = 5'd18;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 2;
         if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_valid beat=%0d got=%b exp=1", i, m_valid); end
         if (m_data !== exp_wrap[i]) begin failures++; $display("[TB] FAIL wrap_data beat=%0d got=%h exp=%h", i, m_data, exp_wrap[i]); end
      end
      @(negedge clk);
      checks += 3;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_end_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd18) begin failures++; $display("[TB] FAIL wrap_rd_ptr got=%0d exp=18", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
   endtask

   task automatic test_flush();
      do_reset();
      m_ready = 1'b0;
      wr_ptr  = 5'd10;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre_valid got=%b exp=1", m_valid); end
      if (empty !== 1'b0) begin failures++; $display("[TB] FAIL flush_pre_empty got=%b exp=0", empty); end
      flush   = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks += 4;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd10) begin failures++; $display("[TB] FAIL flush_rd_ptr got=%0d exp=10", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty got=%b exp=1", empty); end
      if (ram_rd_address !== 4'd10) begin failures++; $display("[TB] FAIL flush_addr got=%0d exp=10", ram_rd_address); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_stale cyc=%0d got=%b exp=0", c, m_valid); end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      load_a0();
      m_ready = 1'b1;
      wr_ptr  = 5'd4;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (m_data !== 8'hA1) begin failures++; $display("[TB] FAIL mid_pre_data got=%h exp=a1", m_data); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks += 3;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b exp=0", m_valid); end
      if (rd_ptr !== 5'd0) begin failures++; $display("[TB] FAIL mid_rd_ptr got=%0d exp=0", rd_ptr); end
      if (ram_rd_address !== 4'd0) begin failures++; $display("[TB] FAIL mid_addr got=%0d exp=0", ram_rd_address); end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_n1_valid got=%b exp=0", m_valid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 2;
         if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_restart_valid beat=%0d got=%b exp=1", i, m_valid); end
         if (m_data !== 8'hA0 + 8'(i)) begin failures++; $display("[TB] FAIL mid_restart_data beat=%0d got=%h exp=%h", i, m_data, 8'hA0 + 8'(i)); end
      end
      @(negedge clk);
      checks += 2;
      if (rd_ptr !== 5'd4) begin failures++; $display("[TB] FAIL mid_end_rd_ptr got=%0d exp=4", rd_ptr); end
      if (empty !== 1'b1) begin failures++; $display("[TB] FAIL mid_end_empty got=%b exp=1", empty); end
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_ptr  = '0;
      flush   = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         ram[i] = 8'h00;
      test_reset();
      test_stream();
      test_backpressure();
      test_wrap();
      test_flush();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
